// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: memory handshake and datapath control bundle for the sequencer
interface multicycle_sequencer_if;
    logic       start;
    logic       stop;
    logic [2:0] opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       register_write;
    logic       memory_to_register;
    logic [2:0] aluop;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic [7:0] instr_count;
    logic       fault;
    logic [2:0] state;
    modport master (
        output start, stop, opcode, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, register_write, memory_to_register,
        input  aluop, alusrc, memread, memwrite, instr_count, fault, state
    );
    modport slave (
        input  start, stop, opcode, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, register_write, memory_to_register,
        output aluop, alusrc, memread, memwrite, instr_count, fault, state
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/exec/mem/wb control FSM with retire counter and sticky fault
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input logic                   clk,
    input logic                   rst,
    multicycle_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } state_t;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_LW  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b101;
    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] cnt_q, cnt_d, wait_q, wait_d;
    logic       ready, timeout, retire, act, is_lw, is_sw;
    state_t     after_retire;
    assign is_lw        = op_q == OP_LW;
    assign is_sw        = op_q == OP_SW;
    assign ready        = state_q == MEM ? bus.dmem_ready : bus.imem_ready;
    assign timeout      = !ready && wait_q == 8'(MEM_TIMEOUT - 1);
    assign retire       = state_q == WB || (state_q == MEM && bus.dmem_ready && is_sw);
    assign after_retire = bus.stop ? IDLE : FETCH;
    assign cnt_d        = cnt_q + {7'd0, retire};
    // Counter only runs while stalled; any exit from FETCH/MEM leaves it cleared for the next entry
    assign wait_d       = ((state_q == FETCH || state_q == MEM) && !ready) ? wait_q + 8'd1 : 8'd0;
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            IDLE:    state_d = bus.start ? FETCH : IDLE;
            FETCH:   state_d = bus.imem_ready ? DECODE : timeout ? FAULT : FETCH;
            DECODE: begin
                op_d    = bus.opcode;
                state_d = (bus.opcode[2] || bus.opcode == OP_ADD) ? EXEC : FAULT;
            end
            EXEC:    state_d = (is_lw || is_sw) ? MEM : WB;
            MEM:     state_d = bus.dmem_ready ? (is_lw ? WB : after_retire) : timeout ? FAULT : MEM;
            WB:      state_d = after_retire;
            default: state_d = FAULT;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 3'b000;
            cnt_q   <= 8'd0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end
    assign act                    = state_q == EXEC || state_q == MEM || state_q == WB;
    assign bus.imem_req           = state_q == FETCH;
    assign bus.ir_write           = state_q == FETCH && bus.imem_ready;
    assign bus.pc_write           = state_q == FETCH && bus.imem_ready;
    assign bus.register_write     = state_q == WB;
    assign bus.memory_to_register = state_q == WB && is_lw;
    assign bus.aluop              = act ? op_q : 3'b000;
    assign bus.alusrc             = act && (op_q == OP_ADD || is_lw || is_sw);
    assign bus.memread            = state_q == MEM && is_lw;
    assign bus.memwrite           = state_q == MEM && is_sw;
    assign bus.instr_count        = cnt_q;
    assign bus.fault              = state_q == FAULT;
    assign bus.state              = state_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized instruction streams checked against a per-instruction state-sequence model
module tb_multicycle_sequencer;
    localparam int TO = 4;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;
    localparam logic [2:0] ADD = 3'b000, ADDI = 3'b100, LW = 3'b110, SW = 3'b101, SLL = 3'b111;
    typedef struct packed {
        logic [2:0] st;
        logic       ir;
        logic       dr;
    } ent_t;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cnt = 0;
    logic [2:0] legal [5] = '{ADD, ADDI, LW, SW, SLL};
    ent_t q[$];
    multicycle_sequencer_if ifc ();
    multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_ctl(input logic [2:0] st, input logic [2:0] op, input logic ir);
        logic a;
        a = st == S_EXEC || st == S_MEM || st == S_WB;
        return {st == S_FETCH, st == S_FETCH && ir, st == S_FETCH && ir, st == S_WB,
                st == S_WB && op == LW, a ? op : 3'b000, a && (op == ADD || op == LW || op == SW),
                st == S_MEM && op == LW, st == S_MEM && op == SW, st == S_FAULT};
    endfunction

    function automatic logic [11:0] obs();
        return {ifc.imem_req, ifc.ir_write, ifc.pc_write, ifc.register_write, ifc.memory_to_register,
                ifc.aluop, ifc.alusrc, ifc.memread, ifc.memwrite, ifc.fault};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input string tag, input logic [2:0] st, input logic [2:0] op, input logic ir);
        #2;
        check({tag, " state"}, 32'(ifc.state), 32'(st));
        check({tag, " ctl"}, 32'(obs()), 32'(exp_ctl(st, op, ir)));
        check({tag, " count"}, 32'(ifc.instr_count), 32'(cnt));
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cnt = 0;
        sample("reset", S_IDLE, ADD, 1'b0);
        step();
        rst = 1'b0;
    endtask

    task automatic go(input logic stp);
        ifc.start      = 1'b0;
        ifc.imem_ready = 1'($urandom);
        ifc.dmem_ready = 1'($urandom);
        sample("idle", S_IDLE, ADD, 1'b0);
        step();
        ifc.start = 1'b1;
        ifc.stop  = stp;
        sample("idle_start", S_IDLE, ADD, 1'b0);
        step();
        ifc.start = 1'b0;
    endtask

    task automatic run_instr(input logic [2:0] op, input int wi, input int wd, input logic stp,
                             output logic faulted);
        ent_t e;
        int   n;
        q.delete();
        faulted = 1'b0;
        n = wi < TO ? wi + 1 : TO;
        for (int k = 0; k < n; k++) q.push_back({S_FETCH, k == wi, 1'($urandom)});
        if (wi >= TO) q.push_back({S_FAULT, 2'($urandom)});
        else begin
            q.push_back({S_DECODE, 2'($urandom)});
            if (!(op[2] || op == ADD)) q.push_back({S_FAULT, 2'($urandom)});
            else begin
                q.push_back({S_EXEC, 2'($urandom)});
                if (op == LW || op == SW) begin
                    n = wd < TO ? wd + 1 : TO;
                    for (int k = 0; k < n; k++) q.push_back({S_MEM, 1'($urandom), k == wd});
                    if (wd >= TO) q.push_back({S_FAULT, 2'($urandom)});
                end
                if (op != SW && q[q.size()-1].st != S_FAULT) q.push_back({S_WB, 2'($urandom)});
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            ifc.imem_ready = e.ir;
            ifc.dmem_ready = e.dr;
            ifc.opcode     = e.st == S_FETCH ? 3'($urandom) : op;
            ifc.start      = 1'($urandom);
            ifc.stop       = i == q.size() - 1 ? stp : 1'($urandom);
            sample("instr", e.st, op, e.ir);
            step();
        end
        if (q[q.size()-1].st == S_FAULT) faulted = 1'b1;
        else cnt = (cnt + 1) % 256;
    endtask

    task automatic fault_hold();
        for (int i = 0; i < 3; i++) begin
            ifc.start      = 1'b1;
            ifc.imem_ready = 1'($urandom);
            ifc.dmem_ready = 1'($urandom);
            ifc.opcode     = 3'($urandom);
            sample("fault_hold", S_FAULT, ADD, 1'b0);
            step();
        end
        ifc.start = 1'b0;
    endtask

    initial begin
        logic f;
        logic [2:0] op;
        int r;
        ifc.start = 1'b0; ifc.stop = 1'b0; ifc.opcode = 3'b000;
        ifc.imem_ready = 1'b0; ifc.dmem_ready = 1'b0;
        reset_dut();
        go(1'b0);
        run_instr(ADD, 0, 0, 1'b0, f);
        run_instr(LW, 0, 3, 1'b0, f);
        run_instr(SW, 0, 0, 1'b1, f);
        go(1'b1);
        run_instr(ADDI, 1, 0, 1'b1, f);
        go(1'b0);
        run_instr(3'b010, 0, 0, 1'b0, f);
        fault_hold();
        reset_dut();
        go(1'b0);
        run_instr(ADD, TO, 0, 1'b0, f);
        fault_hold();
        reset_dut();
        go(1'b0);
        run_instr(ADD, TO - 1, 0, 1'b0, f);
        run_instr(LW, 0, TO, 1'b0, f);
        fault_hold();
        reset_dut();
        go(1'b0);
        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 19);
            op = r == 0 ? 3'($urandom_range(1, 3)) : legal[$urandom_range(0, 4)];
            run_instr(op, r == 1 ? TO : $urandom_range(0, TO - 1), r == 2 ? TO : $urandom_range(0, TO - 1),
                      $urandom_range(0, 3) == 0, f);
            if (f) begin
                fault_hold();
                reset_dut();
                go(1'($urandom));
            end else if (ifc.state == S_IDLE) go(1'($urandom));
        end
        reset_dut();
        go(1'b0);
        for (int i = 0; i < 256; i++) run_instr(SLL, $urandom_range(0, 1), 0, 1'b0, f);
        check("wrap", 32'(ifc.instr_count), 32'd0);
        run_instr(SLL, 0, 0, 1'b0, f);
        ifc.imem_ready = 1'b1;
        sample("pre_abort", S_FETCH, SLL, 1'b1);
        step();
        ifc.opcode = ADD;
        sample("pre_abort", S_DECODE, ADD, 1'b0);
        step();
        sample("pre_abort", S_EXEC, ADD, 1'b0);
        reset_dut();
        sample("post_abort", S_IDLE, ADD, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the 8-bit non-pipelined processor. It steps each instruction through fetch, decode, execute, memory and writeback states. It handshakes with instruction and data memory, and drives the datapath control lines (register write, ALU op/source, memory read/write, writeback mux) only in the cycle each is needed. It also counts retired instructions and traps illegal opcodes and memory timeouts into a sticky fault state.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive not-ready cycles tolerated in FETCH or MEM (legal range 1..255).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- start  in  1  level; leaves IDLE.
- stop  in  1  level; sampled at retire; returns to IDLE instead of fetching.
- opcode  in  3  instruction opcode from the instruction register; valid from DECODE onward.
- imem_ready  in  1  instruction memory has data this cycle.
- dmem_ready  in  1  data memory completed the access this cycle.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load instruction register (1-cycle pulse).
- pc_write  out  1  increment PC (1-cycle pulse, same cycle as ir_write).
- register_write  out  1  register file write enable.
- memory_to_register  out  1  writeback mux: 1 = memory data, 0 = ALU result.
- aluop  out  3  ALU operation; equals the latched opcode.
- alusrc  out  1  ALU B source: 1 = register, 0 = immediate.
- memread  out  1  data memory read.
- memwrite  out  1  data memory write.
- instr_count  out  8  retired instruction count, wraps 255->0.
- fault  out  1  sticky fault flag.
- state  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6. Codes 7 and above go to FAULT.
- Legal opcodes: ADD 000, ADDI 100, LW 110, SW 101, SLL 111. Opcodes 001, 010 and 011 are illegal.
- IDLE: all outputs 0. start=1 -> FETCH.
- FETCH: imem_req=1. With imem_ready=1: ir_write=1 and pc_write=1 for that cycle, then -> DECODE.
- DECODE: opcode is latched into an internal register (op_q).
  - Legal opcode -> EXEC.
  - Illegal opcode -> FAULT.
- op_q drives aluop from EXEC through the end of the instruction. It holds its value in IDLE/FETCH and is not cleared.
- alusrc is decoded from op_q: ADD 1, ADDI 0, SLL 0, LW 1, SW 1. It is driven in EXEC, MEM and WB, and is 0 elsewhere.
- EXEC: ADD, ADDI, SLL -> WB. LW, SW -> MEM.
- MEM: memread=1 (LW) or memwrite=1 (SW), held steady until dmem_ready=1.
  - LW -> WB.
  - SW retires.
- WB: register_write=1 for exactly one cycle. memory_to_register=1 only for LW. Then retire.
- Retire (leaving WB, or leaving MEM for SW): instr_count increments by 1. Next state is IDLE if stop=1, else FETCH.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle ready is low.
  - If ready=0 and counter == MEM_TIMEOUT-1 -> FAULT.
  - Ready high on any of the first MEM_TIMEOUT cycles proceeds normally.
- FAULT: fault=1, all other control outputs 0, instr_count frozen. Only reset exits.
- Outputs are Moore except ir_write/pc_write, which are the combination of FETCH and imem_ready.
- No output is ever X.

## Timing
- Reset (asynchronous, active-high):
  - State is IDLE and op_q=000.
  - instr_count=0 and fault=0.
  - All control outputs 0.
- Reset mid-instruction aborts it with no retire. Any memread/memwrite drops in the same cycle as reset.
- Zero-wait memories:
  - ADD/ADDI/SLL take 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW takes 5 cycles (FETCH, DECODE, EXEC, MEM, WB).
  - SW takes 4 cycles (FETCH, DECODE, EXEC, MEM).
- Each wait cycle adds one cycle in FETCH or MEM.
- start is ignored outside IDLE. stop is only sampled at retire.
- If start and stop are both high in IDLE, execution still begins. One instruction retires, then the sequencer returns to IDLE.
- instr_count at 255 retires to 0, with no flag.

## Test plan
- Reset, start=1, ADD with ready always 1 -> state 1,2,3,5 then 1. register_write high only in the WB cycle with aluop=000, alusrc=1. instr_count=1.
- LW with dmem_ready low for 3 cycles -> memread held 4 cycles, then WB with memory_to_register=1 and register_write=1. Total 8 cycles.
- SW followed by stop=1 -> memwrite for one cycle, register_write never 1, count increments, state returns to IDLE.
- Illegal opcode 010 in DECODE -> FAULT next cycle, fault=1, all enables 0. start has no effect. Reset clears fault.
- MEM_TIMEOUT=4, imem_ready held 0 -> FAULT after exactly 4 FETCH cycles. A repeat run with ready asserted on the 4th cycle proceeds to DECODE.
- Run 256 SLL instructions -> instr_count wraps to 0. An async reset asserted mid-EXEC clears state, count and outputs without waiting for a clock edge.
